// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a registered result stage, plus iterative unsigned multiply and divide.
module alu_seq #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [4:0]   ALUfn,
  input  logic [1:0]   mdop,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] R,
  output logic [N-1:0] Rhi,
  output logic         FlagN,
  output logic         FlagV,
  output logic         FlagC,
  output logic         FlagZ,
  output logic         FlagDZ
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state_q;
  logic [N-1:0]  hi_q, lo_q, m_q, r_q, rhi_q;
  logic [SW-1:0] cnt_q;
  logic          div_q, fn_q, fv_q, fc_q, fz_q, fdz_q;
  logic          accept, md_op, cmp, sub_e, c, v, lt, last, ge;
  logic [N-1:0]  bb, s, sh_r, sra, bool_r, alu_r, nhi, nlo, diff;
  logic [N:0]    msum, r_sh;
  logic [SW-1:0] sh;
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = state_q == DONE;
  assign accept    = in_valid & in_ready;
  assign md_op     = mdop == 2'b01 | mdop == 2'b10;
  assign {R, Rhi}  = {r_q, rhi_q};
  assign {FlagN, FlagV, FlagC, FlagZ, FlagDZ} = {fn_q, fv_q, fc_q, fz_q, fdz_q};
  // Set-less-than forces the adder into A-B so its flags drive the compare.
  assign cmp    = ALUfn[1] & ALUfn[0];
  assign sub_e  = ALUfn[4] | cmp;
  assign bb     = sub_e ? ~B : B;
  assign {c, s} = {1'b0, A} + {1'b0, bb} + (N+1)'(sub_e);
  assign v      = (A[N-1] == bb[N-1]) & (s[N-1] != A[N-1]);
  assign lt     = ALUfn[2] ? ~c : s[N-1] ^ v;
  assign sh     = A[SW-1:0];
  assign sra    = $signed(B) >>> sh;
  assign sh_r   = ALUfn[3] ? (ALUfn[2] ? sra : B >> sh) : B << sh;
  assign bool_r = ALUfn[3] ? (ALUfn[2] ? ~(A | B) : A ^ B) : (ALUfn[2] ? A | B : A & B);
  assign alu_r  = cmp ? N'(lt) : ALUfn[0] ? s : ALUfn[1] ? sh_r : bool_r;
  // One iteration: shift-add multiply shifts right, restoring divide shifts left.
  // A zero divisor always "fits", yielding an all-ones quotient and remainder A.
  assign msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign r_sh = {hi_q, lo_q[N-1]};
  assign ge   = r_sh >= {1'b0, m_q};
  assign diff = r_sh[N-1:0] - m_q;
  assign nhi  = div_q ? (ge ? diff : r_sh[N-1:0]) : msum[N:1];
  assign nlo  = div_q ? {lo_q[N-2:0], ge} : {msum[0], lo_q[N-1:1]};
  assign last = cnt_q == SW'(N - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      {hi_q, lo_q, m_q, r_q, rhi_q} <= '0;
      cnt_q <= '0;
      {div_q, fn_q, fv_q, fc_q, fz_q, fdz_q} <= '0;
    end else if (accept && md_op) begin
      state_q <= BUSY;
      hi_q    <= '0;
      lo_q    <= A;
      m_q     <= B;
      div_q   <= mdop[1];
      cnt_q   <= '0;
    end else if (accept) begin
      state_q <= DONE;
      r_q     <= alu_r;
      rhi_q   <= '0;
      {fn_q, fv_q, fc_q, fz_q, fdz_q} <= {s[N-1], v, c, alu_r == '0, 1'b0};
    end else if (state_q == BUSY) begin
      hi_q  <= nhi;
      lo_q  <= nlo;
      cnt_q <= last ? '0 : cnt_q + 1'b1;
      if (last) begin
        state_q <= DONE;
        r_q     <= nlo;
        rhi_q   <= nhi;
        {fn_q, fv_q, fc_q, fz_q, fdz_q} <= {nlo[N-1], 2'b00, nlo == '0 && nhi == '0, div_q && m_q == '0};
      end
    end else if (state_q == DONE && out_ready) begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int N = 32;
  localparam longint MAXI = 2147483647;
  typedef struct packed {
    logic [31:0] r, rhi;
    logic n, v, c, z, dz;
  } res_t;
  logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, FlagN, FlagV, FlagC, FlagZ, FlagDZ;
  logic [31:0] A = 0, B = 0, R, Rhi;
  logic [4:0] ALUfn = 0;
  logic [1:0] mdop = 0;
  int n_cmp = 0, n_bad = 0;
  res_t last;
  alu_seq #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUfn(ALUfn), .mdop(mdop), .out_valid(out_valid),
    .out_ready(out_ready), .R(R), .Rhi(Rhi), .FlagN(FlagN), .FlagV(FlagV),
    .FlagC(FlagC), .FlagZ(FlagZ), .FlagDZ(FlagDZ)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic res_t model(input logic [31:0] a, b, input logic [4:0] fn, input logic [1:0] md);
    res_t o;
    longint sa, sb, ss;
    logic [32:0] us;
    logic [63:0] p;
    logic sub, cm;
    int sh;
    o = '0;
    sa = $signed(a);
    sb = $signed(b);
    if (md == 2'b01) begin
      p = 64'(a) * 64'(b);
      o.r = p[31:0];
      o.rhi = p[63:32];
    end else if (md == 2'b10) begin
      if (b == 0) begin
        o.r = '1;
        o.rhi = a;
        o.dz = 1;
      end else begin
        o.r = a / b;
        o.rhi = a % b;
      end
    end
    if (md == 2'b01 || md == 2'b10) begin
      o.n = o.r[31];
      o.z = o.r == 0 && o.rhi == 0;
      return o;
    end
    cm = fn[1] & fn[0];
    sub = fn[4] | cm;
    ss = sub ? sa - sb : sa + sb;
    us = sub ? 33'(a) - 33'(b) : 33'(a) + 33'(b);
    o.v = ss > MAXI || ss < -MAXI - 1;
    o.c = sub ? a >= b : us[32];
    o.n = us[31];
    sh = int'(a[4:0]);
    if (cm) o.r = fn[2] ? 32'(a < b) : 32'(sa < sb);
    else if (fn[0]) o.r = us[31:0];
    else if (fn[1]) o.r = fn[3] ? (fn[2] ? 32'(sb >>> sh) : b >> sh) : b << sh;
    else o.r = fn[3] ? (fn[2] ? ~(a | b) : a ^ b) : (fn[2] ? a | b : a & b);
    o.z = o.r == 0;
    return o;
  endfunction
  task automatic chk_out(input string tag, input res_t e);
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_r"}, R, e.r);
    chk({tag, "_rhi"}, Rhi, e.rhi);
    chk({tag, "_flags"}, {FlagN, FlagV, FlagC, FlagZ, FlagDZ}, {e.n, e.v, e.c, e.z, e.dz});
  endtask
  task automatic run_op(input logic [31:0] a, b, input logic [4:0] fn, input logic [1:0] md);
    res_t e;
    int lat;
    e = model(a, b, fn, md);
    @(negedge clk);
    {A, B, ALUfn, mdop, in_valid, out_ready} = {a, b, fn, md, 1'b1, 1'b1};
    @(posedge clk);
    #1 in_valid = 0;
    A = $urandom;
    B = $urandom;
    ALUfn = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", 64'(lat), (md == 2'b01 || md == 2'b10) ? 64'(N + 1) : 64'd1);
    chk_out("op", e);
    last = e;
    @(posedge clk);
    #1 chk("drop", out_valid, 0);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    res_t e, q[$];
    int st;
    #1 chk("rst_ov", out_valid, 0);
    chk("rst_r", {R, Rhi}, 0);
    chk("rst_flags", {FlagN, FlagV, FlagC, FlagZ, FlagDZ}, 0);
    @(negedge clk) reset_n = 1;
    @(posedge clk);
    #1 chk("rst_ready", in_ready, 1);
    run_op(32'h7FFF_FFFF, 32'd1, 5'b00001, 2'b00);
    chk("add_ovf", {last.r, last.v, last.n}, {32'h8000_0000, 2'b11});
    run_op(32'd5, 32'd5, 5'b10001, 2'b00);
    chk("sub_zc", {last.z, last.c}, 2'b11);
    run_op(32'd4, 32'h8000_0000, 5'b01110, 2'b00);
    chk("sra", last.r, 32'hF800_0000);
    run_op(32'hFFFF_FFFF, 32'd1, 5'b00011, 2'b00);
    chk("slt", last.r, 1);
    run_op(32'hFFFF_FFFF, 32'd1, 5'b00111, 2'b00);
    chk("sltu", last.r, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00000, 2'b01);
    chk("mulu", {last.rhi, last.r}, 64'hFFFF_FFFE_0000_0001);
    run_op(32'd100, 32'd7, 5'b00000, 2'b10);
    chk("divu", {last.r, last.rhi, last.dz}, {32'd14, 32'd2, 1'b0});
    run_op(32'd100, 32'd0, 5'b00000, 2'b10);
    chk("divz", {last.r, last.rhi, last.dz}, {32'hFFFF_FFFF, 32'd100, 1'b1});
    for (int i = 0; i < 60; i++) run_op(pick(), pick(), 5'($urandom), 2'($urandom));
    e = model(32'h1234, 32'h0F0F, 5'b01000, 2'b00);
    @(negedge clk);
    {A, B, ALUfn, mdop, in_valid, out_ready} = {32'h1234, 32'h0F0F, 5'b01000, 2'b00, 1'b1, 1'b0};
    @(posedge clk);
    #1 in_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 chk("bp_hold", {out_valid, in_ready, R, FlagZ}, {2'b10, e.r, e.z});
    end
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    #1 chk("bp_release", {out_valid, in_ready}, 2'b01);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) chk_out("b2b", q.pop_front());
      A = $urandom;
      B = $urandom;
      {ALUfn, mdop, in_valid} = {5'b00001, 2'b00, 1'b1};
      q.push_back(model(A, B, ALUfn, mdop));
    end
    @(negedge clk);
    chk_out("b2b", q.pop_front());
    A = $urandom;
    B = $urandom;
    mdop = 2'b01;
    e = model(A, B, ALUfn, mdop);
    @(posedge clk);
    #1 in_valid = 0;
    st = 0;
    for (int k = 0; k < 100 && !out_valid; k++) begin
      if (!in_ready) st++;
      @(posedge clk);
      #1;
    end
    chk("mul_stall", 64'(st), 64'(N));
    chk_out("b2b_mul", e);
    @(posedge clk);
    #1 chk("b2b_idle", out_valid, 0);
    run_op(32'hDEAD_BEEF, 32'h1, 5'b01001, 2'b00);
    @(negedge clk);
    {A, B, mdop, in_valid} = {32'd7, 32'd9, 2'b01, 1'b1};
    @(posedge clk);
    #1 in_valid = 0;
    repeat (4) @(posedge clk);
    #1 reset_n = 0;
    #1 chk("rstmid_out", {out_valid, R, Rhi}, 0);
    chk("rstmid_ready", in_ready, 1);
    @(negedge clk) reset_n = 1;
    repeat (40) begin
      @(posedge clk);
      #1 chk("rstmid_noout", {out_valid, in_ready}, 2'b01);
    end
    run_op(32'd7, 32'd9, 5'b00000, 2'b01);
    chk("rstmid_mul", last.r, 63);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
